reg_file_dump_ctrl: RTL
=======================

// Module: reg_file_dump_ctrl
// PURPOSE
//   Sits directly downstream of Simple_Single_CPU's register file. Counts cycles after reset
//   and, at END_COUNT or on a forced trigger, reads every register through one async read port.
//   Streams each (index, value) pair out on a valid/ready interface to a trace sink or UART bridge.
//   This replaces hierarchical testbench peeking with a synthesizable end-of-run dump.
// PARAMETERS
//   END_COUNT  250  cycles after reset release before the automatic dump starts (>=2)
//   NUM_REGS   32   registers dumped, indices 0..NUM_REGS-1
//   DATA_W     32   register width
//   ADDR_W     5    register-file read address width (2**ADDR_W >= NUM_REGS)
// PORTS
//   clk_i         in   1         clock, all logic on rising edge
//   rst_i         in   1         synchronous active-high reset
//   force_dump_i  in   1         single-cycle pulse that starts the dump immediately (sampled in WAIT only)
//   rf_addr_o     out  ADDR_W    register-file read address
//   rf_data_i     in   DATA_W    register-file read data, combinational from rf_addr_o
//   dump_valid_o  out  1         output beat valid
//   dump_ready_i  in   1         sink ready; a beat transfers on valid&&ready at a rising edge
//   dump_idx_o    out  ADDR_W+1  index of the current beat
//   dump_data_o   out  DATA_W    value of the current beat
//   busy_o        out  1         high in LOAD or SEND
//   done_o        out  1         high in DONE, held until reset
// BEHAVIOUR
//   Clock and reset:
//   - Clock is clk_i. Reset rst_i is synchronous and active-high.
//   - Reset forces: state=WAIT, cycle_cnt=0, idx=0, all outputs 0.
//   - Reset mid-dump aborts the dump. dump_valid_o is low from the next edge, and a partial beat is never completed.
//   Cycle counter:
//   - cycle_cnt increments every edge while rst_i=0 and saturates at END_COUNT.
//   - It keeps counting through the dump but never retriggers one.
//   FSM states: WAIT, LOAD, SEND, DONE.
//   - WAIT -> LOAD when cycle_cnt==END_COUNT-1 or force_dump_i=1. A force and a count match in the
//     same cycle give one dump.
//   - LOAD: drive rf_addr_o=idx. At the edge, capture rf_data_i into dump_data_o and idx into
//     dump_idx_o, set dump_valid_o, go to SEND.
//   - SEND: hold dump_valid_o, dump_idx_o and dump_data_o stable until dump_ready_i=1.
//     Register changes while stalled are not re-sampled.
//   - SEND on a handshake: if idx==NUM_REGS-1, clear valid and go to DONE; otherwise idx++,
//     clear valid and go to LOAD.
//   - DONE: done_o=1. force_dump_i is ignored. Only rst_i leaves DONE.
//   Timing and widths:
//   - Each beat takes 2 cycles minimum, so NUM_REGS beats take 2*NUM_REGS cycles with ready held high.
//   - force_dump_i in LOAD, SEND or DONE has no effect.
//   - rf_addr_o = idx[ADDR_W-1:0]. dump_idx_o is zero-extended to ADDR_W+1 bits.
// CONFIGURATION
//   DUMP_CHECKSUM_EN defined:
//   - A running XOR of all dumped values is kept and cleared on reset.
//   - After the handshake of index NUM_REGS-1, FSM enters SEND with dump_idx_o=NUM_REGS and
//     dump_data_o=XOR. DONE follows after that handshake.
//   DUMP_CHECKSUM_EN undefined:
//   - No checksum logic. Exactly NUM_REGS beats, then DONE.
// TESTING
//   Model register file with NUM_REGS=4, END_COUNT=8, reg[i]=3*i.
//   1 ready=1 -> first valid after 9th edge past reset release; beats (0,0)(1,3)(2,6)(3,9) on
//     alternate cycles; done_o=1 one edge after last beat.
//   2 ready=0 for 5 cycles on beat 1; reg[1] changed to 7 while stalled -> beat stays (1,3),
//     no beat lost or duplicated.
//   3 force_dump_i pulsed at cycle 2 -> dump starts next edge; cycle_cnt reaching 7 during or
//     after the dump does not restart it.
//   4 rst_i=1 one cycle while beat 2 is valid -> dump_valid_o=0 next edge; new dump restarts at
//     (0,0) 8 cycles later.
//   5 force_dump_i and cycle_cnt==7 in the same cycle -> exactly 4 beats.
//   6 DUMP_CHECKSUM_EN -> 5th beat (4,0xC); done_o only after it; without macro done_o after 4 beats.

Source files
------------

// File: rtl/reg_file_dump_ctrl.sv
// End-of-run register file dump: after END_COUNT cycles or a forced trigger, streams
// every register as an (index, value) beat. Define DUMP_CHECKSUM_EN to append an XOR checksum beat.
module reg_file_dump_ctrl #(
  parameter int END_COUNT = 250,
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              force_dump_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W:0]   dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(END_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(END_COUNT);
  localparam logic [CNT_W-1:0]  CNT_TRIG = CNT_W'(END_COUNT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {WAIT, LOAD, SEND, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [ADDR_W-1:0] idx;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CHK_IDX = (ADDR_W + 1)'(NUM_REGS);
  logic [DATA_W-1:0] chk;
`endif

  assign rf_addr_o = idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= WAIT;
      cycle_cnt    <= '0;
      idx          <= '0;
      dump_valid_o <= 1'b0;
      dump_idx_o   <= '0;
      dump_data_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      chk          <= '0;
`endif
    end else begin
      if (cycle_cnt != CNT_MAX)
        cycle_cnt <= cycle_cnt + 1'b1;
      case (state)
        WAIT: begin
          if (cycle_cnt == CNT_TRIG || force_dump_i) begin
            state  <= LOAD;
            busy_o <= 1'b1;
          end
        end
        LOAD: begin
          dump_data_o  <= rf_data_i;
          dump_idx_o   <= {1'b0, idx};
          dump_valid_o <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          // Beat is frozen until accepted; the register file is not re-read while stalled.
          if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            chk <= chk ^ dump_data_o;
            if (dump_idx_o == CHK_IDX) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else if (idx == LAST_IDX) begin
              dump_valid_o <= 1'b1;
              dump_idx_o   <= CHK_IDX;
              dump_data_o  <= chk ^ dump_data_o;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
`else
            if (idx == LAST_IDX) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
`endif
          end
        end
        DONE: begin
          done_o <= 1'b1;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule
